// File: rtl/cci_mpf_svc_vtp_tlb_server.sv
// VTP TLB server: a direct-mapped VA-page -> PA-index cache with two
// independent lookup ports, each with a fixed 2-cycle hit/miss latency, and
// one fill port written by the page-table-walk miss handler.
module cci_mpf_svc_vtp_tlb_server #(
  parameter int VA_PAGE_BITS = 36,
  parameter int PA_IDX_BITS  = 20,
  parameter int NUM_SETS     = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0][VA_PAGE_BITS-1:0]     lookupPageVA,
  input  logic [1:0]                       lookupEn,
  output logic [1:0]                       lookupRdy,
  output logic [1:0][PA_IDX_BITS-1:0]      lookupRspPagePA,
  output logic [1:0]                       lookupValid,
  output logic [1:0]                       lookupMiss,
  output logic [1:0][VA_PAGE_BITS-1:0]     lookupMissVA,
  input  logic                             fillEn,
  input  logic [VA_PAGE_BITS-1:0]          fillVA,
  input  logic [PA_IDX_BITS-1:0]           fillPA,
  output logic                             fillRdy
);

  // state    | meaning
  // ST_INIT  | walking initIdx over every set, clearing its valid bit; not ready
  // ST_RUN   | serving lookups and fills every cycle; never stalls

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = VA_PAGE_BITS - IDX_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state;
  state_t              stateNext;
  logic [IDX_BITS-1:0] initIdx;
  logic                runRdy;

  // Table storage; only the valid bits need clearing, tag/PA are don't-care until filled.
  logic [NUM_SETS-1:0] tblValid;
  logic [TAG_BITS-1:0] tblTag [NUM_SETS];
  logic [PA_IDX_BITS-1:0] tblPA [NUM_SETS];

  logic                fillDo;
  logic [IDX_BITS-1:0] fillIdx;

  // Stage 1 (cycle T+1): captured request plus the entry read at the end of T.
  logic [1:0]                   s1Valid;
  logic [1:0][VA_PAGE_BITS-1:0] s1VA;
  logic [1:0]                   s1EntValid;
  logic [1:0][TAG_BITS-1:0]     s1Tag;
  logic [1:0][PA_IDX_BITS-1:0]  s1PA;
  logic [1:0]                   s1Hit;

  // State register and init sweep counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      initIdx <= '0;
    end else begin
      state <= stateNext;
      if (state == ST_INIT) initIdx <= initIdx + IDX_BITS'(1);
    end
  end

  // Next-state and ready decode.
  always_comb begin
    stateNext = state;
    runRdy    = 1'b0;
    case (state)
      ST_INIT: if (initIdx == IDX_BITS'(NUM_SETS - 1)) stateNext = ST_RUN;
      ST_RUN:  runRdy = 1'b1;
      default: stateNext = ST_INIT;
    endcase
  end

  assign lookupRdy = {2{runRdy}};
  assign fillRdy   = runRdy;
  assign fillDo    = fillEn && fillRdy;
  assign fillIdx   = fillVA[IDX_BITS-1:0];

  // Table write: init sweep clears, fills overwrite whatever the set held.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      tblValid[initIdx] <= 1'b0;
    end else if (fillDo) begin
      tblValid[fillIdx] <= 1'b1;
      tblTag[fillIdx]   <= fillVA[VA_PAGE_BITS-1:IDX_BITS];
      tblPA[fillIdx]    <= fillPA;
    end
  end

  // Stage-1 request valid bits; cleared by reset so in-flight lookups vanish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid <= '0;
    end else begin
      for (int p = 0; p < 2; p++) s1Valid[p] <= lookupEn[p] && lookupRdy[p];
    end
  end

  // Stage-1 data: table read happens at the same edge as a fill, so it sees pre-fill contents.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      s1VA[p]       <= lookupPageVA[p];
      s1EntValid[p] <= tblValid[lookupPageVA[p][IDX_BITS-1:0]];
      s1Tag[p]      <= tblTag[lookupPageVA[p][IDX_BITS-1:0]];
      s1PA[p]       <= tblPA[lookupPageVA[p][IDX_BITS-1:0]];
    end
  end

  // Tag compare in T+1.
  always_comb begin
    for (int p = 0; p < 2; p++)
      s1Hit[p] = s1EntValid[p] && (s1Tag[p] == s1VA[p][VA_PAGE_BITS-1:IDX_BITS]);
  end

  // Stage-2 response registers (cycle T+2); PA holds across misses, miss VA holds across hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookupValid     <= '0;
      lookupMiss      <= '0;
      lookupRspPagePA <= '0;
      lookupMissVA    <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        lookupValid[p] <= s1Valid[p] && s1Hit[p];
        lookupMiss[p]  <= s1Valid[p] && !s1Hit[p];
        if (s1Valid[p] && s1Hit[p])  lookupRspPagePA[p] <= s1PA[p];
        if (s1Valid[p] && !s1Hit[p]) lookupMissVA[p]    <= s1VA[p];
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_svc_vtp_tlb_server.sv
// Scoreboard bench for the VTP TLB server: directed lookups push expected
// responses; a negedge monitor pops and checks every hit/miss pulse.
module tb_cci_mpf_svc_vtp_tlb_server;
  localparam int VA = 36;
  localparam int PA = 20;
  localparam int NUM_SETS = 256;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0][VA-1:0] lookupPageVA = '0;
  logic [1:0]         lookupEn = '0;
  logic [1:0]         lookupRdy;
  logic [1:0][PA-1:0] lookupRspPagePA;
  logic [1:0]         lookupValid;
  logic [1:0]         lookupMiss;
  logic [1:0][VA-1:0] lookupMissVA;
  logic               fillEn = 1'b0;
  logic [VA-1:0]      fillVA = '0;
  logic [PA-1:0]      fillPA = '0;
  logic               fillRdy;

  cci_mpf_svc_vtp_tlb_server #(.VA_PAGE_BITS(VA), .PA_IDX_BITS(PA), .NUM_SETS(NUM_SETS)) dut (
    .clk(clk), .reset(reset),
    .lookupPageVA(lookupPageVA), .lookupEn(lookupEn), .lookupRdy(lookupRdy),
    .lookupRspPagePA(lookupRspPagePA), .lookupValid(lookupValid), .lookupMiss(lookupMiss),
    .lookupMissVA(lookupMissVA),
    .fillEn(fillEn), .fillVA(fillVA), .fillPA(fillPA), .fillRdy(fillRdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    logic [VA-1:0] va;
    logic [PA-1:0] pa;
    int          cyc;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [PA-1:0] lastPA [2];
  int            cyc = 0;
  int            tests = 0;
  int            failures = 0;
  int            pulseCnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int p, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s port%0d: got 0x%0h expected 0x%0h (cyc %0d)", name, p, act, expv, cyc);
    end
  endtask

  // Responses leave in issue order, so the last-hit PA model advances at push time.
  task automatic expectRsp(input int p, input bit hit, input logic [VA-1:0] va, input logic [PA-1:0] pa);
    exp_t e;
    if (hit) lastPA[p] = pa;
    e.hit = hit;
    e.va  = va;
    e.pa  = hit ? pa : lastPA[p];
    e.cyc = cyc + 2;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic lookup(input int p, input logic [VA-1:0] va, input bit hit, input logic [PA-1:0] pa);
    lookupEn[p]     = 1'b1;
    lookupPageVA[p] = va;
    expectRsp(p, hit, va, pa);
  endtask

  task automatic fill(input logic [VA-1:0] va, input logic [PA-1:0] pa);
    fillEn = 1'b1;
    fillVA = va;
    fillPA = pa;
  endtask

  task automatic step();
    @(negedge clk);
    lookupEn = '0;
    fillEn   = 1'b0;
  endtask

  task automatic checkPort(input int p);
    exp_t e;
    bit   have;
    pulseCnt++;
    have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (!have) begin
      tests++;
      failures++;
      $display("FAIL unexpected_rsp port%0d: got valid=%b miss=%b expected no pulse (cyc %0d)",
               p, lookupValid[p], lookupMiss[p], cyc);
      return;
    end
    e = (p == 0) ? q0.pop_front() : q1.pop_front();
    chk("rsp_kind", p, {62'd0, lookupValid[p], lookupMiss[p]}, e.hit ? 64'd2 : 64'd1);
    chk("rsp_cycle", p, 64'(cyc), 64'(e.cyc));
    chk("rsp_pa", p, 64'(lookupRspPagePA[p]), 64'(e.pa));
    if (!e.hit) chk("miss_va", p, 64'(lookupMissVA[p]), 64'(e.va));
  endtask

  // Monitor: every response pulse must match the head of its port's scoreboard.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++)
      if (lookupValid[p] || lookupMiss[p]) checkPort(p);
  end

  // Counts not-ready cycles from reset release; ends on a negedge.
  task automatic initCount();
    int n;
    n = 0;
    #1;
    while (fillRdy !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    lookupEn = '0;
    fillEn   = 1'b0;
    chk("init_cycles", 0, 64'(n), 64'(NUM_SETS));
    chk("lookup_rdy_run", 0, 64'(lookupRdy), 64'd3);
  endtask

  initial begin
    int n;
    int pc;
    lastPA[0] = '0;
    lastPA[1] = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_lookupRdy", 0, 64'(lookupRdy), 64'd0);
    chk("rst_fillRdy", 0, 64'(fillRdy), 64'd0);
    chk("rst_valid", 0, 64'(lookupValid), 64'd0);
    chk("rst_miss", 0, 64'(lookupMiss), 64'd0);
    chk("rst_pa", 0, 64'(lookupRspPagePA), 64'd0);
    chk("rst_missva", 0, 64'(lookupMissVA), 64'd0);
    reset = 1'b0;
    initCount();

    // Cold lookup misses.
    lookup(0, 36'h5, 1'b0, '0);
    step();

    // Fill then hit on port 1.
    fill(36'h123, 20'hABCD);
    step();
    lookup(1, 36'h123, 1'b1, 20'hABCD);
    step();

    // Same-cycle fill and lookup: read-before-write, then hit.
    fill(36'h40, 20'h4444);
    lookup(0, 36'h40, 1'b0, '0);
    step();
    lookup(0, 36'h40, 1'b1, 20'h4444);
    step();

    // Set conflict: second fill overwrites the first.
    fill(36'h001, 20'h11);
    step();
    fill(36'h101, 20'h22);
    step();
    lookup(0, 36'h001, 1'b0, '0);
    lookup(1, 36'h101, 1'b1, 20'h22);
    step();

    // Streaming: both ports, 8 back-to-back, alternating hit/miss.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        lookup(0, 36'h123, 1'b1, 20'hABCD);
        lookup(1, 36'h777, 1'b0, '0);
      end else begin
        lookup(0, 36'h777, 1'b0, '0);
        lookup(1, 36'h101, 1'b1, 20'h22);
      end
      step();
    end

    // Both ports miss on the same VA, then both hit the same VA.
    lookup(0, 36'h999, 1'b0, '0);
    lookup(1, 36'h999, 1'b0, '0);
    step();
    lookup(0, 36'h40, 1'b1, 20'h4444);
    lookup(1, 36'h40, 1'b1, 20'h4444);
    step();

    // Drain before the reset test.
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain1", 0, 64'(q0.size() + q1.size()), 64'd0);

    // Reset with two lookups in flight: no pulses, INIT repeats.
    lookupEn        = 2'b11;
    lookupPageVA[0] = 36'h123;
    lookupPageVA[1] = 36'h40;
    step();
    pc = pulseCnt;
    reset = 1'b1;
    #1;
    chk("midrst_rdy", 0, 64'(lookupRdy), 64'd0);
    repeat (3) @(negedge clk);
    lastPA[0] = '0;
    lastPA[1] = '0;
    // Requests and a fill held through INIT must all be ignored.
    lookupEn        = 2'b11;
    lookupPageVA[0] = 36'h555;
    lookupPageVA[1] = 36'h555;
    fill(36'h555, 20'h55);
    reset = 1'b0;
    initCount();
    chk("midrst_no_pulse", 0, 64'(pulseCnt), 64'(pc));

    // Prior fills and the INIT-time fill are gone.
    lookup(0, 36'h123, 1'b0, '0);
    lookup(1, 36'h555, 1'b0, '0);
    step();
    fill(36'h123, 20'h0BEEF);
    step();
    lookup(0, 36'h123, 1'b1, 20'h0BEEF);
    step();

    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain2", 0, 64'(q0.size() + q1.size()), 64'd0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
